instruction_cache: RTL
======================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch stage and
//  instruction_memory. Returns a 32-bit instruction to the CPU on a hit in the
//  same cycle. On a miss it initiates a 16-byte block read on the memory's
//  read/busywait interface, fills the line and then serves the instruction.
// PARAMETERS
//  ADDR_BITS   10  CPU byte address width; memory block address is ADDR_BITS-4 (6)
//  INDEX_BITS  3   line index width; 2**INDEX_BITS (8) lines of 128 bits each
//                  tag width = ADDR_BITS-4-INDEX_BITS (3)
// PORTS
//  clock          in   1    system clock, rising-edge active
//  reset          in   1    asynchronous, active-low reset (0 = reset)
//  read           in   1    CPU fetch request
//  address        in   10   CPU byte address (PC); [1:0] ignored
//  instruction    out  32   fetched instruction word
//  busywait       out  1    CPU stall; 1 while the request is not yet served
//  mem_read       out  1    block read request to instruction memory
//  mem_address    out  6    memory block address (byte address[9:4])
//  mem_readinst   in   128  block data; byte k of block at bits [8k+7:8k]
//  mem_busywait   in   1    memory busy; rises on mem_read, falls when data valid
// BEHAVIOUR
//  Address split: tag=[9:7], index=[6:4], word=[3:2]; word w = block bits [32w+31:32w].
//  Storage: valid[8], tag[8] (3b), data[8] (128b). Only valid bits are reset.
//  hit = valid[index] && tag[index]==address tag (combinational).
//  instruction = selected word when hit, else 32'h0 (combinational).
//  FSM states: IDLE, MEM_READ, UPDATE.
//   IDLE: busywait = read && !hit. On a rising edge with read && !hit:
//     latch tag/index into a miss register and go to MEM_READ.
//   MEM_READ: mem_read=1, mem_address={latched tag,index}, busywait=1.
//     mem_busywait is ignored on the entry edge. On the first later rising
//     edge where mem_busywait==0: write mem_readinst to data[latched index],
//     write the latched tag, set valid, and go to UPDATE.
//   UPDATE: mem_read=0, busywait=1, for one cycle, then IDLE. A re-lookup in
//     IDLE then hits and drops busywait in the same cycle.
//  Miss latency: 1 (entry) + memory time + 1 (UPDATE) cycles; hit latency 0.
//  In IDLE, mem_read=0 and mem_address=0.
//  The fill always uses the latched address. If address or read changes during
//   MEM_READ or UPDATE, the fill still completes. The new address is looked up in IDLE.
//  Once started, a fill is never aborted; only reset cancels it.
//  Reset (reset==0, any state, asynchronous): state=IDLE, all valid=0, miss
//   register=0, mem_read=0 immediately. While reset is held, busywait=0 and
//   instruction=0. After release, an in-flight memory completion is ignored.
//   The first request after release is a cold miss.
//  Simultaneous hit and miss cannot occur: there is one request port and no
//   hit-under-miss, so busywait covers the whole miss.
// TESTING
//  1 reset 0->1, read=1, addr=0x000 -> busywait=1; next edge mem_read=1,
//    mem_address=6'h00; mem model returns words 0xA0..0xA3 -> instruction=0xA0,
//    busywait=0 one cycle after UPDATE.
//  2 After test 1, addr 0x004/0x008/0x00C -> hits: instruction 0xA1/0xA2/0xA3,
//    busywait=0 in the same cycle, mem_read never asserted.
//  3 Conflict: addr 0x080 (index 0, tag 1) -> miss, mem_address=6'h08, refill.
//    Then addr 0x000 misses again with mem_address=6'h00.
//  4 Miss on 0x010, then change address to 0x3F0 one cycle into MEM_READ ->
//    line 1 is filled with tag 0 from mem_address 6'h01; 0x3F0 then misses
//    with mem_address=6'h3F.
//  5 Hold mem_busywait=1 for 20 cycles -> stays in MEM_READ with mem_read=1 and
//    busywait=1 throughout; fill completes on the first edge with mem_busywait=0.
//  6 Assert reset mid-MEM_READ -> mem_read=0 and busywait=0 without waiting for
//    a clock edge; after release, addr 0x000 is a miss.

Source files
------------

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, grouped as one bundle.
// The cache takes the slave view; the CPU/memory side (or a bench) takes the master view.
interface instruction_cache_if #(
  parameter int ADDR_BITS = 10
);
  logic                 read;
  logic [ADDR_BITS-1:0] address;
  logic [31:0]          instruction;
  logic                 busywait;
  logic                 mem_read;
  logic [ADDR_BITS-5:0] mem_address;
  logic [127:0]         mem_readinst;
  logic                 mem_busywait;

  modport slave (
    input  read, address, mem_readinst, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output read, address, mem_readinst, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 16-byte block refill
// from instruction memory on a miss, stalling the fetch stage until the line is filled.
module instruction_cache #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input logic              clock,
  input logic              reset,
  instruction_cache_if.slave bus
);
  localparam int BLOCK_BITS = ADDR_BITS - 4;
  localparam int TAG_BITS   = BLOCK_BITS - INDEX_BITS;
  localparam int LINES      = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                  state_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [127:0]            data_q [LINES];
  logic [TAG_BITS-1:0]     missTag_q;
  logic [INDEX_BITS-1:0]   missIndex_q;
  logic                    memRead_q;
  logic [BLOCK_BITS-1:0]   memAddress_q;

  logic [TAG_BITS-1:0]     addrTag;
  logic [INDEX_BITS-1:0]   addrIndex;
  logic [1:0]              addrWord;
  logic [127:0]            lineData;
  logic                    hit;
  logic                    fillEn;
  logic                    unusedAddrBits;

  assign addrTag        = bus.address[ADDR_BITS-1 -: TAG_BITS];
  assign addrIndex      = bus.address[4 +: INDEX_BITS];
  assign addrWord       = bus.address[3:2];
  assign unusedAddrBits = ^bus.address[1:0];

  assign lineData = data_q[addrIndex];
  assign hit      = valid_q[addrIndex] && (tag_q[addrIndex] == addrTag);
  assign fillEn   = (state_q == MEM_READ) && !bus.mem_busywait;

  assign bus.instruction = hit ? lineData[{addrWord, 5'b00000} +: 32] : 32'h0;
  // Gated by reset so the CPU is never stalled while the cache is held in reset.
  assign bus.busywait    = reset && ((state_q != IDLE) || (bus.read && !hit));
  assign bus.mem_read    = memRead_q;
  assign bus.mem_address = memAddress_q;

  // Control FSM; the miss register keeps the fill address stable if the CPU address moves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      missTag_q    <= '0;
      missIndex_q  <= '0;
      memRead_q    <= 1'b0;
      memAddress_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.read && !hit) begin
            missTag_q    <= addrTag;
            missIndex_q  <= addrIndex;
            memRead_q    <= 1'b1;
            memAddress_q <= {addrTag, addrIndex};
            state_q      <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!bus.mem_busywait) begin
            valid_q[missIndex_q] <= 1'b1;
            memRead_q            <= 1'b0;
            memAddress_q         <= '0;
            state_q              <= UPDATE;
          end
        end
        UPDATE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clock) begin
    if (fillEn) begin
      data_q[missIndex_q] <= bus.mem_readinst;
      tag_q[missIndex_q]  <= missTag_q;
    end
  end
endmodule
